// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Constants and types shared by the register file and its
//                issue-side scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int NUM_REGS   = 12;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 2;
    localparam int ZERO_REG   = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      cnt_t;

    localparam cnt_t CNT_MAX = '1;

    // r0 is hard-wired and never owes a write-back, so it is not tracked.
    function automatic logic is_tracked(input reg_addr_t a);
        return (a != REG_ADDR_W'(ZERO_REG)) && (a < REG_ADDR_W'(NUM_REGS));
    endfunction

    function automatic logic out_of_range(input reg_addr_t a);
        return a >= REG_ADDR_W'(NUM_REGS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard_if.sv
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Issue / write-back / status bundle of the register scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_scoreboard_if;
    import regfile_pkg::*;

    logic                idIssue;
    logic                idUsesRs;
    logic                idUsesRt;
    reg_addr_t           idRs;
    reg_addr_t           idRt;
    logic                idWritesReg;
    reg_addr_t           idDest;
    logic                WBregWrite;
    reg_addr_t           WBwriteReg;
    logic                idStall;
    logic [NUM_REGS-1:0] pendingMask;
    logic                scbErr;

    modport master (
        output idIssue, idUsesRs, idUsesRt, idRs, idRt, idWritesReg, idDest,
        output WBregWrite, WBwriteReg,
        input  idStall, pendingMask, scbErr
    );

    modport slave (
        input  idIssue, idUsesRs, idUsesRt, idRs, idRt, idWritesReg, idDest,
        input  WBregWrite, WBwriteReg,
        output idStall, pendingMask, scbErr
    );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard_scb_counter.sv
// ============================================================================
//  Module      : scb_counter
//  Description : Saturating up/down count of write-backs owed to one register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scb_counter
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic nonzero_o,
    output logic underflow_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Simultaneous inc and dec hand ownership to the new writer: no change.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign nonzero_o   = (cnt_q != '0);
    assign underflow_o = dec_i && (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register pending-write tracking and decode stall logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    cnt_t                w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [NUM_REGS-1:0] w_nonzero;
    logic [NUM_REGS-1:0] w_underflow;
    logic                w_stall;
    logic                w_accept;
    logic                w_err_now;
    logic                err_q;
    logic                err_d;

    assign w_cnt[0]       = '0;
    assign w_inc[0]       = 1'b0;
    assign w_dec[0]       = 1'b0;
    assign w_nonzero[0]   = 1'b0;
    assign w_underflow[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
            assign w_inc[gi] = w_accept && bus.idWritesReg &&
                               (bus.idDest == REG_ADDR_W'(gi));
            assign w_dec[gi] = bus.WBregWrite &&
                               (bus.WBwriteReg == REG_ADDR_W'(gi));

            scb_counter u_counter (
                .clk         (clk),
                .rst_n       (rst_n),
                .inc_i       (w_inc[gi]),
                .dec_i       (w_dec[gi]),
                .cnt_o       (w_cnt[gi]),
                .nonzero_o   (w_nonzero[gi]),
                .underflow_o (w_underflow[gi])
            );
        end
    endgenerate

    function automatic cnt_t cnt_at(input reg_addr_t a);
        return is_tracked(a) ? w_cnt[a[IDX_W-1:0]] : '0;
    endfunction

    function automatic logic dec_at(input reg_addr_t a);
        return is_tracked(a) ? w_dec[a[IDX_W-1:0]] : 1'b0;
    endfunction

    // A write-back landing this cycle retires the last owner in time for the
    // read, since the file writes in clk-high and reads in clk-low.
    function automatic logic busy(input reg_addr_t a);
        return (cnt_at(a) != '0) && !(dec_at(a) && (cnt_at(a) == cnt_t'(1)));
    endfunction

    always_comb begin
        w_stall = 1'b0;
        if (bus.idIssue) begin
            w_stall = (bus.idUsesRs    && busy(bus.idRs)) ||
                      (bus.idUsesRt    && busy(bus.idRt)) ||
                      (bus.idWritesReg && (cnt_at(bus.idDest) == CNT_MAX) &&
                                          !dec_at(bus.idDest));
        end
    end

    assign w_accept = bus.idIssue && !w_stall;

    assign w_err_now = (|w_underflow) ||
                       (bus.idUsesRs && out_of_range(bus.idRs)) ||
                       (bus.idUsesRt && out_of_range(bus.idRt)) ||
                       (w_accept && bus.idWritesReg && out_of_range(bus.idDest)) ||
                       (bus.WBregWrite && out_of_range(bus.WBwriteReg));

    assign err_d = err_q || w_err_now;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.idStall     = w_stall;
    assign bus.pendingMask = w_nonzero;
    assign bus.scbErr      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench for regfile_scoreboard against a count model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;
    import regfile_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [12:0] exp_q [$];   // {scbErr, pendingMask} expected after each edge
    int          m_cnt [NUM_REGS];
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_busy(input int r, input logic wbw, input int wbr);
        if (r <= 0 || r >= NUM_REGS) return 1'b0;
        return (m_cnt[r] != 0) && !(wbw && wbr == r && m_cnt[r] == 1);
    endfunction

    function automatic logic [12:0] m_status();
        logic [11:0] mk;
        mk = '0;
        for (int r = 1; r < NUM_REGS; r++) mk[r] = (m_cnt[r] != 0);
        return {m_err, mk};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) m_cnt[r] = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle of stimulus at posedge+1, sample at negedge, return at posedge+1.
    task automatic apply(input logic iss, input logic ur, input int rs, input logic ut,
                         input int rt, input logic wr, input int dst, input logic wbw,
                         input int wbr, input int want_stall);
        logic        st, acc, inc, dec;
        logic [12:0] e;
        bus.idIssue     = iss;
        bus.idUsesRs    = ur;
        bus.idRs        = REG_ADDR_W'(rs);
        bus.idUsesRt    = ut;
        bus.idRt        = REG_ADDR_W'(rt);
        bus.idWritesReg = wr;
        bus.idDest      = REG_ADDR_W'(dst);
        bus.WBregWrite  = wbw;
        bus.WBwriteReg  = REG_ADDR_W'(wbr);
        @(negedge clk);
        st = iss && ((ur && m_busy(rs, wbw, wbr)) || (ut && m_busy(rt, wbw, wbr)) ||
                     (wr && dst > 0 && dst < NUM_REGS && m_cnt[dst] == 3 &&
                      !(wbw && wbr == dst)));
        check("idStall", bus.idStall, st);
        if (want_stall >= 0) check("idStall_plan", bus.idStall, want_stall[0]);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e = exp_q.pop_front();
            check("pendingMask", bus.pendingMask, e[11:0]);
            check("scbErr", bus.scbErr, e[12]);
        end
        acc = iss && !st;
        if (ur && rs >= NUM_REGS) m_err = 1'b1;
        if (ut && rt >= NUM_REGS) m_err = 1'b1;
        if (acc && wr && dst >= NUM_REGS) m_err = 1'b1;
        if (wbw && wbr >= NUM_REGS) m_err = 1'b1;
        for (int r = 1; r < NUM_REGS; r++) begin
            inc = acc && wr && dst == r;
            dec = wbw && wbr == r;
            if (dec && m_cnt[r] == 0) m_err = 1'b1;
            if (inc && !dec && m_cnt[r] < 3) m_cnt[r]++;
            else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
        end
        exp_q.push_back(m_status());
        @(posedge clk);
        #1;
    endtask

    task automatic idle();             apply(0,0,0,0,0,0,0,0,0,-1);    endtask
    task automatic wb(input int r);    apply(0,0,0,0,0,0,0,1,r,-1);    endtask
    task automatic iss_wr(input int d, input int want); apply(1,0,0,0,0,1,d,0,0,want); endtask

    // Asserted mid-cycle (posedge+1): outputs must clear without waiting for an edge.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_mask"}, bus.pendingMask, '0);
        check({tag, "_err"}, bus.scbErr, 1'b0);
        bus.idIssue  = 1'b1;
        bus.idUsesRs = 1'b1;
        bus.idRs     = REG_ADDR_W'(3);
        #1;
        check({tag, "_stall"}, bus.idStall, 1'b0);
        bus.idIssue  = 1'b0;
        bus.idUsesRs = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(m_status());
    endtask

    initial begin
        bus.idIssue = 0; bus.idUsesRs = 0; bus.idUsesRt = 0; bus.idRs = '0; bus.idRt = '0;
        bus.idWritesReg = 0; bus.idDest = '0; bus.WBregWrite = 0; bus.WBwriteReg = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset("por");

        // Read-after-write and same-cycle write-back bypass on r5
        iss_wr(5, 0);
        apply(1,1,5,0,0,0,0,0,0,1);
        apply(1,1,5,0,0,0,0,1,5,0);
        idle();

        // Saturation on r7
        iss_wr(7, 0); iss_wr(7, 0); iss_wr(7, 0);
        iss_wr(7, 1);
        apply(1,0,0,0,0,1,7,1,7,0);
        idle();
        wb(7); wb(7); wb(7);
        idle();

        // Same-cycle issue and write-back on r2 transfers ownership
        iss_wr(2, 0);
        apply(1,0,0,0,0,1,2,1,2,0);
        apply(1,0,0,1,2,0,0,0,0,1);
        wb(2);
        idle();

        // r0 is never tracked; out-of-range write-back is sticky
        iss_wr(0, 0);
        wb(13);
        for (int i = 0; i < 10; i++) idle();

        // Build cnt[3]=2 and reset in the middle of it
        iss_wr(3, 0); iss_wr(3, 0);
        idle();
        do_reset("midrst");

        // Underflow on r4
        wb(4);
        idle(); idle();
        do_reset("rst2");

        // Mixed traffic
        for (int i = 0; i < 300; i++) begin
            apply(1'($urandom_range(0,1)), 1'($urandom_range(0,1)), $urandom_range(0,11),
                  1'($urandom_range(0,1)), $urandom_range(0,11),
                  1'($urandom_range(0,1)), $urandom_range(0,11),
                  1'($urandom_range(0,2) == 0), $urandom_range(1,11), -1);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule

`default_nettype wire
